// File: rtl/frame_rx.sv
// Purpose: frame receiver; SOF plus M-1 words go to header registers, next N words to the data FIFO.
// Latency: every output is registered, so strobes appear one clock after the accepted word.
// Backpressure: none upstream; a data word arriving while fifo_full is set is dropped and marks the frame bad.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   rx_valid/rx_data/rx_sof  receive word stream; rx_sof marks header word 0
//   fifo_full              downstream data FIFO cannot take a write
//   hdr_we/hdr_addr/hdr_data  header register write port
//   fifo_wr/fifo_din       data FIFO write port
//   frame_done/frame_err   one-cycle end-of-frame status pulses
//   frame_cnt              count of good frames (wraps)
//   busy                   receiver is inside a frame
module frame_rx #(
    parameter int M = 4,
    parameter int N = 4096,
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rx_valid,
    input  logic [W-1:0] rx_data,
    input  logic         rx_sof,
    input  logic         fifo_full,
    output logic         hdr_we,
    output logic [1:0]   hdr_addr,
    output logic [W-1:0] hdr_data,
    output logic         fifo_wr,
    output logic [W-1:0] fifo_din,
    output logic         frame_done,
    output logic         frame_err,
    output logic [15:0]  frame_cnt,
    output logic         busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic [1:0]  HDR_LAST = 2'(M - 1);
    localparam logic [15:0] DAT_LAST = 16'(N - 1);

    state_t         state_q, state_d;
    logic [1:0]     hdr_cnt_q, hdr_cnt_d;
    logic [15:0]    dat_cnt_q, dat_cnt_d;
    logic           ovf_q, ovf_d;
    logic           hdr_we_q, hdr_we_d;
    logic [1:0]     hdr_addr_q, hdr_addr_d;
    logic [W-1:0]   hdr_data_q, hdr_data_d;
    logic           fifo_wr_q, fifo_wr_d;
    logic [W-1:0]   fifo_din_q, fifo_din_d;
    logic           done_q, done_d;
    logic           err_q, err_d;
    logic [15:0]    frame_cnt_q, frame_cnt_d;
    logic           busy_q, busy_d;
    logic           ovf_now;

    always_comb begin
        state_d     = state_q;
        hdr_cnt_d   = hdr_cnt_q;
        dat_cnt_d   = dat_cnt_q;
        ovf_d       = ovf_q;
        hdr_we_d    = 1'b0;
        hdr_addr_d  = hdr_addr_q;
        hdr_data_d  = hdr_data_q;
        fifo_wr_d   = 1'b0;
        fifo_din_d  = fifo_din_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        frame_cnt_d = frame_cnt_q;
        ovf_now     = ovf_q | fifo_full;

        if (rx_valid) begin
            if (rx_sof) begin
                // SOF always starts a new frame; inside a frame it aborts the old one,
                // including on what would have been the last data word.
                err_d      = (state_q != IDLE);
                ovf_d      = 1'b0;
                hdr_we_d   = 1'b1;
                hdr_addr_d = 2'd0;
                hdr_data_d = rx_data;
                dat_cnt_d  = 16'd0;
                if (HDR_LAST == 2'd0) begin
                    hdr_cnt_d = 2'd0;
                    state_d   = DATA;
                end else begin
                    hdr_cnt_d = 2'd1;
                    state_d   = HDR;
                end
            end else begin
                case (state_q)
                    HDR: begin
                        hdr_we_d   = 1'b1;
                        hdr_addr_d = hdr_cnt_q;
                        hdr_data_d = rx_data;
                        if (hdr_cnt_q == HDR_LAST) begin
                            hdr_cnt_d = 2'd0;
                            dat_cnt_d = 16'd0;
                            state_d   = DATA;
                        end else begin
                            hdr_cnt_d = hdr_cnt_q + 2'd1;
                        end
                    end
                    DATA: begin
                        if (!fifo_full) begin
                            fifo_wr_d  = 1'b1;
                            fifo_din_d = rx_data;
                        end
                        // Dropped words still count toward N so the frame ends on time.
                        if (dat_cnt_q == DAT_LAST) begin
                            if (ovf_now) begin
                                err_d = 1'b1;
                            end else begin
                                done_d      = 1'b1;
                                frame_cnt_d = frame_cnt_q + 16'd1;
                            end
                            ovf_d     = 1'b0;
                            dat_cnt_d = 16'd0;
                            state_d   = IDLE;
                        end else begin
                            ovf_d     = ovf_now;
                            dat_cnt_d = dat_cnt_q + 16'd1;
                        end
                    end
                    default: ; // IDLE: words without SOF are ignored
                endcase
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hdr_cnt_q   <= 2'd0;
            dat_cnt_q   <= 16'd0;
            ovf_q       <= 1'b0;
            hdr_we_q    <= 1'b0;
            hdr_addr_q  <= 2'd0;
            hdr_data_q  <= '0;
            fifo_wr_q   <= 1'b0;
            fifo_din_q  <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hdr_cnt_q   <= hdr_cnt_d;
            dat_cnt_q   <= dat_cnt_d;
            ovf_q       <= ovf_d;
            hdr_we_q    <= hdr_we_d;
            hdr_addr_q  <= hdr_addr_d;
            hdr_data_q  <= hdr_data_d;
            fifo_wr_q   <= fifo_wr_d;
            fifo_din_q  <= fifo_din_d;
            done_q      <= done_d;
            err_q       <= err_d;
            frame_cnt_q <= frame_cnt_d;
            busy_q      <= busy_d;
        end
    end

    assign hdr_we     = hdr_we_q;
    assign hdr_addr   = hdr_addr_q;
    assign hdr_data   = hdr_data_q;
    assign fifo_wr    = fifo_wr_q;
    assign fifo_din   = fifo_din_q;
    assign frame_done = done_q;
    assign frame_err  = err_q;
    assign frame_cnt  = frame_cnt_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_frame_rx.sv
// Directed bench for frame_rx: main instance M=4/N=8, plus an M=1/N=1 instance for counter wrap.
module tb_frame_rx;

    localparam int M = 4;
    localparam int N = 8;
    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         rx_valid, rx_sof, fifo_full;
    logic [W-1:0] rx_data;
    logic         hdr_we, fifo_wr, frame_done, frame_err, busy;
    logic [1:0]   hdr_addr;
    logic [W-1:0] hdr_data, fifo_din;
    logic [15:0]  frame_cnt;

    logic         w_valid, w_sof, w_full;
    logic [W-1:0] w_data;
    logic         w_hdr_we, w_fifo_wr, w_done, w_err, w_busy;
    logic [1:0]   w_hdr_addr;
    logic [W-1:0] w_hdr_data, w_fifo_din;
    logic [15:0]  w_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    frame_rx #(.M(M), .N(N), .W(W)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data), .rx_sof(rx_sof),
        .fifo_full(fifo_full), .hdr_we(hdr_we), .hdr_addr(hdr_addr), .hdr_data(hdr_data),
        .fifo_wr(fifo_wr), .fifo_din(fifo_din), .frame_done(frame_done), .frame_err(frame_err),
        .frame_cnt(frame_cnt), .busy(busy)
    );

    frame_rx #(.M(1), .N(1), .W(W)) u_wrap (
        .clk(clk), .rst_n(rst_n), .rx_valid(w_valid), .rx_data(w_data), .rx_sof(w_sof),
        .fifo_full(w_full), .hdr_we(w_hdr_we), .hdr_addr(w_hdr_addr), .hdr_data(w_hdr_data),
        .fifo_wr(w_fifo_wr), .fifo_din(w_fifo_din), .frame_done(w_done), .frame_err(w_err),
        .frame_cnt(w_cnt), .busy(w_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Output monitor: logs strobes one step after each rising edge.
    int          hdr_addr_log[$];
    logic [W-1:0] hdr_data_log[$];
    logic [W-1:0] fifo_log[$];
    int          n_done, n_err, n_spur, n_wdone;
    logic        mon_v;

    always @(posedge clk) begin
        mon_v = rx_valid;
        #1;
        if (hdr_we) begin
            hdr_addr_log.push_back(int'(hdr_addr));
            hdr_data_log.push_back(hdr_data);
        end
        if (fifo_wr) fifo_log.push_back(fifo_din);
        if (frame_done) n_done++;
        if (frame_err) n_err++;
        if ((hdr_we || fifo_wr) && !mon_v) n_spur++;
        if (w_done) n_wdone++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] hdr_d_at(int i);
        return (i < hdr_data_log.size()) ? hdr_data_log[i] : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] hdr_a_at(int i);
        return (i < hdr_addr_log.size()) ? 32'(hdr_addr_log[i]) : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] fifo_at(int i);
        return (i < fifo_log.size()) ? fifo_log[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_logs();
        hdr_addr_log.delete();
        hdr_data_log.delete();
        fifo_log.delete();
        n_done = 0;
        n_err  = 0;
        n_spur = 0;
    endtask

    task automatic put(input logic sof, input logic [31:0] d, input logic full, input int gap);
        @(negedge clk);
        rx_valid  = 1'b1;
        rx_sof    = sof;
        rx_data   = d;
        fifo_full = full;
        repeat (gap) begin
            @(negedge clk);
            rx_valid  = 1'b0;
            rx_sof    = 1'b0;
            fifo_full = 1'b0;
            rx_data   = 32'h0BAD_0BAD;
        end
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        rx_valid  = 1'b0;
        rx_sof    = 1'b0;
        fifo_full = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Word i of a frame carries base+i; full_at is the data index sent with fifo_full.
    task automatic send_frame(input logic [31:0] base, input int gap, input int full_at, input int nwords);
        for (int i = 0; i < nwords; i++)
            put(i == 0, base + 32'(i), (i - M) == full_at, gap);
    endtask

    task automatic wput(input logic sof, input logic [31:0] d);
        @(negedge clk);
        w_valid = 1'b1;
        w_sof   = sof;
        w_data  = d;
    endtask

    task automatic widle();
        @(negedge clk);
        w_valid = 1'b0;
        w_sof   = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_hdr(input string tag, input int idx, input int addr, input logic [31:0] d);
        chk({tag, "_addr"}, hdr_a_at(idx), 32'(addr));
        chk({tag, "_data"}, hdr_d_at(idx), d);
    endtask

    initial begin
        rst_n = 1'b0; rx_valid = 1'b0; rx_sof = 1'b0; fifo_full = 1'b0; rx_data = '0;
        w_valid = 1'b0; w_sof = 1'b0; w_full = 1'b0; w_data = '0;
        clear_logs();
        n_wdone = 0;

        #3;
        chk("rst_hdr_we", 32'(hdr_we), 0);
        chk("rst_fifo_wr", 32'(fifo_wr), 0);
        chk("rst_frame_cnt", 32'(frame_cnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done_err", 32'({frame_done, frame_err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Words without SOF while idle are ignored.
        clear_logs();
        put(0, 32'h1111, 0, 0);
        put(0, 32'h2222, 1, 0);
        put(0, 32'h3333, 0, 0);
        idle(2);
        chk("idle_hdr_cnt", 32'(hdr_data_log.size()), 0);
        chk("idle_fifo_cnt", 32'(fifo_log.size()), 0);
        chk("idle_err", 32'(n_err), 0);
        chk("idle_busy", 32'(busy), 0);

        // Contiguous good frame, with one-cycle latency checked on the SOF word.
        clear_logs();
        @(negedge clk);
        rx_valid = 1'b1; rx_sof = 1'b1; rx_data = 32'hA000;
        #1 chk("lat_pre_edge", 32'(hdr_we), 0);
        @(posedge clk);
        #1;
        chk("lat_hdr_we", 32'(hdr_we), 1);
        chk("lat_busy", 32'(busy), 1);
        for (int i = 1; i < 12; i++) put(0, 32'hA000 + 32'(i), 0, 0);
        idle(3);
        chk("t1_hdr_cnt", 32'(hdr_data_log.size()), 4);
        for (int i = 0; i < 4; i++) check_hdr("t1_hdr", i, i, 32'hA000 + 32'(i));
        chk("t1_fifo_cnt", 32'(fifo_log.size()), 8);
        for (int i = 0; i < 8; i++) chk("t1_fifo", fifo_at(i), 32'hA004 + 32'(i));
        chk("t1_done", 32'(n_done), 1);
        chk("t1_err", 32'(n_err), 0);
        chk("t1_cnt", 32'(frame_cnt), 1);
        chk("t1_busy", 32'(busy), 0);
        chk("t1_hdr_hold", hdr_data, 32'hA003);
        chk("t1_fifo_hold", fifo_din, 32'hA00B);

        // Same frame with a stall after every word.
        clear_logs();
        send_frame(32'hB000, 1, -1, 12);
        idle(3);
        chk("t2_hdr_cnt", 32'(hdr_data_log.size()), 4);
        for (int i = 0; i < 4; i++) check_hdr("t2_hdr", i, i, 32'hB000 + 32'(i));
        chk("t2_fifo_cnt", 32'(fifo_log.size()), 8);
        for (int i = 0; i < 8; i++) chk("t2_fifo", fifo_at(i), 32'hB004 + 32'(i));
        chk("t2_spur", 32'(n_spur), 0);
        chk("t2_done", 32'(n_done), 1);
        chk("t2_cnt", 32'(frame_cnt), 2);

        // FIFO full on data word 3: word dropped, frame reported bad.
        clear_logs();
        send_frame(32'hC000, 0, 3, 12);
        idle(3);
        chk("t3_fifo_cnt", 32'(fifo_log.size()), 7);
        chk("t3_fifo2", fifo_at(2), 32'hC006);
        chk("t3_fifo3", fifo_at(3), 32'hC008);
        chk("t3_done", 32'(n_done), 0);
        chk("t3_err", 32'(n_err), 1);
        chk("t3_cnt", 32'(frame_cnt), 2);

        // Overflow on data 2, then SOF at data 5; new frame must complete cleanly.
        clear_logs();
        send_frame(32'hD000, 0, 2, 9);
        send_frame(32'hE000, 0, -1, 12);
        idle(3);
        chk("t4_hdr_cnt", 32'(hdr_data_log.size()), 8);
        check_hdr("t4_new_hdr0", 4, 0, 32'hE000);
        check_hdr("t4_new_hdr3", 7, 3, 32'hE003);
        chk("t4_fifo_cnt", 32'(fifo_log.size()), 12);
        chk("t4_err", 32'(n_err), 1);
        chk("t4_done", 32'(n_done), 1);
        chk("t4_cnt", 32'(frame_cnt), 3);

        // SOF on the last data word aborts rather than completing.
        clear_logs();
        send_frame(32'hF000, 0, -1, 11);
        send_frame(32'h7000, 0, -1, 12);
        idle(3);
        chk("t5_fifo_cnt", 32'(fifo_log.size()), 15);
        chk("t5_err", 32'(n_err), 1);
        chk("t5_done", 32'(n_done), 1);
        chk("t5_cnt", 32'(frame_cnt), 4);

        // Asynchronous reset mid-DATA.
        clear_logs();
        send_frame(32'h5000, 0, -1, 7);
        @(posedge clk);
        #2;
        rx_valid = 1'b0; rx_sof = 1'b0;
        chk("pre_rst_fifo_wr", 32'(fifo_wr), 1);
        rst_n = 1'b0;
        #1;
        chk("arst_fifo_wr", 32'(fifo_wr), 0);
        chk("arst_fifo_din", fifo_din, 0);
        chk("arst_hdr_data", hdr_data, 0);
        chk("arst_cnt", 32'(frame_cnt), 0);
        chk("arst_busy", 32'(busy), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle(1);
        chk("arst_no_pulse", 32'(n_done + n_err), 0);
        clear_logs();
        send_frame(32'h6000, 0, -1, 12);
        idle(3);
        chk("post_rst_hdr0", hdr_d_at(0), 32'h6000);
        chk("post_rst_done", 32'(n_done), 1);
        chk("post_rst_cnt", 32'(frame_cnt), 1);

        // Frame counter wrap on the M=1/N=1 instance.
        n_wdone = 0;
        for (int i = 0; i < 3; i++) begin
            wput(1, 32'h100 + 32'(i));
            wput(0, 32'h200 + 32'(i));
        end
        widle();
        chk("w_cnt3", 32'(w_cnt), 3);
        chk("w_done3", 32'(n_wdone), 3);
        // Shortcut to the top of the range instead of clocking tens of thousands of frames.
        @(negedge clk);
        force u_wrap.frame_cnt_q = 16'hFFFE;
        @(posedge clk);
        #1 release u_wrap.frame_cnt_q;
        chk("w_preload", 32'(w_cnt), 32'hFFFE);
        wput(1, 32'h300); wput(0, 32'h301);
        widle();
        chk("w_cnt_ffff", 32'(w_cnt), 32'hFFFF);
        wput(1, 32'h400); wput(0, 32'h401);
        widle();
        chk("w_cnt_wrap", 32'(w_cnt), 32'h0000);
        chk("w_done5", 32'(n_wdone), 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
